// File: rtl/sat_mac16_if.sv
// ----------------------------------------------------------------------------
// sat_mac16_if
// Groups the command and result signals of the sat_mac16 multiply-accumulate
// unit. The master side issues commands; the slave side is the MAC itself.
//   start   : begin an operation (accepted only when the MAC is idle)
//   clr_acc : clear acc and ovf (accepted only when the MAC is idle)
//   a, b    : signed 16-bit operands, latched when start is accepted
//   busy    : operation in progress
//   done    : one-cycle pulse, acc/ovf have just been updated
//   acc     : signed 16-bit saturating accumulator
//   ovf     : sticky saturation flag
// ----------------------------------------------------------------------------
interface sat_mac16_if;
   logic        start;
   logic        clr_acc;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] acc;
   logic        ovf;

   modport master (output start, clr_acc, a, b,
                   input  busy, done, acc, ovf);

   modport slave  (input  start, clr_acc, a, b,
                   output busy, done, acc, ovf);
endinterface

// File: rtl/sat_mac16.sv
// ----------------------------------------------------------------------------
// sat_mac16
// Iterative signed 16x16 multiply-accumulate with saturating 16-bit
// accumulation. Each operation runs a 16-cycle unsigned shift-add on the
// operand magnitudes, clamps the signed product to 16 bits, then adds it to
// the accumulator with saturation (the CLA_16bit saturating-add function).
// Start-to-done latency is 18 cycles.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sat_mac16_if.slave (start, clr_acc, a, b / busy, done, acc, ovf)
// ----------------------------------------------------------------------------
module sat_mac16 (
   input  logic        clk,
   input  logic        rst_n,
   sat_mac16_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MUL, SAT, ACC} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] mag_a;      // |a|, |0x8000| = 0x8000
   logic [15:0] mag_b;      // |b|
   logic        sign;       // sign of the true product
   logic [31:0] prod;       // magnitude product pm
   logic [3:0]  cnt;        // multiplier bit index
   logic [15:0] psat;       // clamped signed product
   logic        povf;       // product clamp happened
   logic [15:0] acc_q;
   logic        ovf_q;
   logic        done_q;

   logic [15:0] psat_c;
   logic        povf_c;
   logic [16:0] sum17;
   logic [15:0] sum_sat;
   logic        aovf;

   // ---------------- state register ----------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   // NOTE: each combinational output gets a default first; a path that left
   // it unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = MUL;
         MUL:     if (cnt == 4'd15) state_nxt = SAT;
         SAT:     state_nxt = ACC;
         ACC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- product clamp and saturating add ----------------
   always_comb begin
      povf_c = 1'b0;
      psat_c = sign ? -prod[15:0] : prod[15:0];   // pm = 0 gives 0 for either sign
      if (!sign && prod > 32'h0000_7FFF) begin
         psat_c = 16'h7FFF;
         povf_c = 1'b1;
      end else if (sign && prod > 32'h0000_8000) begin
         psat_c = 16'h8000;
         povf_c = 1'b1;
      end

      // Overflow is only possible with equal operand signs; it shows up as
      // bit16 != bit15 of the sign-extended sum, and the clamp direction
      // follows the shared operand sign.
      sum17   = {acc_q[15], acc_q} + {psat[15], psat};
      aovf    = (acc_q[15] == psat[15]) && (sum17[16] != sum17[15]);
      sum_sat = sum17[15:0];
      if (aovf) sum_sat = acc_q[15] ? 16'h8000 : 16'h7FFF;
   end

   // ---------------- datapath ----------------
   // NOTE: every internal register is reset as well, so an aborted operation
   // leaves no stale operand or product behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a  <= '0;
         mag_b  <= '0;
         sign   <= 1'b0;
         prod   <= '0;
         cnt    <= '0;
         psat   <= '0;
         povf   <= 1'b0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == ACC);
         case (state)
            IDLE: begin
               // Clear and start in the same cycle: the clear lands now, the
               // new product is accumulated onto 0 eighteen cycles later.
               if (bus.clr_acc) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
               end
               if (bus.start) begin
                  mag_a <= bus.a[15] ? -bus.a : bus.a;
                  mag_b <= bus.b[15] ? -bus.b : bus.b;
                  sign  <= bus.a[15] ^ bus.b[15];
                  prod  <= '0;
                  cnt   <= '0;
               end
            end
            MUL: begin
               if (mag_b[cnt]) prod <= prod + ({16'd0, mag_a} << cnt);
               cnt <= cnt + 4'd1;
            end
            SAT: begin
               psat <= psat_c;
               povf <= povf_c;
            end
            ACC: begin
               acc_q <= sum_sat;
               ovf_q <= ovf_q | povf | aovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
   assign bus.acc  = acc_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sat_mac16.sv
// ----------------------------------------------------------------------------
// tb_sat_mac16
// Directed test of sat_mac16. Inputs change on the falling edge, outputs are
// sampled on the falling edge. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_sat_mac16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;   // rising edges since the edge that accepted start

   sat_mac16_if bus ();

   sat_mac16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Called on a falling edge; returns on the falling edge after E0.
   // Operands are scrambled right after acceptance to show they are latched.
   task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic clr);
      bus.a       = av;
      bus.b       = bv;
      bus.start   = 1'b1;
      bus.clr_acc = clr;
      @(posedge clk);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.clr_acc = 1'b0;
      bus.a       = 16'hDEAD;
      bus.b       = 16'hBEEF;
      cyc         = 0;
   endtask

   task automatic wait_done(input string tag);
      while (bus.done !== 1'b1 && cyc < 40) tick();
      check({tag, ".latency"}, cyc, 18);
   endtask

   task automatic clear(input string tag);
      bus.clr_acc = 1'b1;
      tick();
      bus.clr_acc = 1'b0;
      check({tag, ".acc"}, bus.acc, 16'h0000);
      check({tag, ".ovf"}, bus.ovf, 1'b0);
   endtask

   task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                     input logic clr, input logic [15:0] exp_acc, input logic exp_ovf);
      start_op(av, bv, clr);
      check({tag, ".busy_run"}, bus.busy, 1'b1);
      wait_done(tag);
      check({tag, ".acc"},       bus.acc,  exp_acc);
      check({tag, ".ovf"},       bus.ovf,  exp_ovf);
      check({tag, ".busy_done"}, bus.busy, 1'b0);
      tick();
      check({tag, ".done_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      logic done_seen;

      // ---- reset ----
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.clr_acc = 1'b0;
      bus.a       = '0;
      bus.b       = '0;
      #1;
      check("rst.acc",  bus.acc,  16'h0000);
      check("rst.ovf",  bus.ovf,  1'b0);
      check("rst.busy", bus.busy, 1'b0);
      check("rst.done", bus.done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---- basic products and signed accumulation ----
      clear("clr0");
      op("p3x4",  16'h0003, 16'h0004, 1'b0, 16'h000C, 1'b0);
      op("m5x7",  16'hFFFB, 16'h0007, 1'b0, 16'hFFE9, 1'b0);   // 12 - 35 = -23

      // ---- product clamp ----
      clear("clr1");
      op("big",   16'h0100, 16'h0100, 1'b0, 16'h7FFF, 1'b1);   // 65536 -> 0x7FFF
      clear("clr2");
      op("minsq", 16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1);   // +2^30 -> 0x7FFF
      clear("clr3");
      op("minx1", 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0);   // exact -32768
      clear("clr4");
      op("zero",  16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0);   // negative zero

      // ---- accumulate clamp: 181*181 = 32761 (0x7FF9), +6 lands on 0x7FFF ----
      clear("clr5");
      op("pre1",  16'h00B5, 16'h00B5, 1'b0, 16'h7FF9, 1'b0);
      op("pre2",  16'h0006, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
      op("accov", 16'h0001, 16'h0001, 1'b0, 16'h7FFF, 1'b1);

      // ---- start/clr_acc while busy are ignored ----
      clear("clr6");
      op("two",   16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0);
      start_op(16'h0002, 16'h0002, 1'b0);
      while (cyc < 4) tick();
      bus.start   = 1'b1;
      bus.clr_acc = 1'b1;
      bus.a       = 16'h7000;
      bus.b       = 16'h7000;
      tick();
      bus.start   = 1'b0;
      bus.clr_acc = 1'b0;
      check("busy_pulse.acc_hold", bus.acc, 16'h0004);
      wait_done("busy_pulse");
      check("busy_pulse.acc", bus.acc, 16'h0008);
      check("busy_pulse.ovf", bus.ovf, 1'b0);
      tick();

      // ---- reset in flight aborts the operation ----
      start_op(16'h0002, 16'h0002, 1'b0);
      while (cyc < 7) tick();
      rst_n = 1'b0;
      #1;
      check("abort.acc",  bus.acc,  16'h0000);
      check("abort.ovf",  bus.ovf,  1'b0);
      check("abort.busy", bus.busy, 1'b0);
      check("abort.done", bus.done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 1'b0;
      repeat (25) begin
         tick();
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      check("abort.no_done", done_seen, 1'b0);

      // ---- fresh operation, then clear+start in the same cycle ----
      op("fresh",    16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0);
      op("clrstart", 16'h0003, 16'h0003, 1'b1, 16'h0009, 1'b0);   // 0 + 9

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
